dp_load_sequencer: RTL

Upstream control stage for dotProduct. It accepts operand beats over a valid/ready stream and writes them into the two input SRAMs and the one old-output SRAM at incrementing addresses. It then sequences the compute phase (PE clear, Computing window) and captures the final result. It replaces file-driven loading with a synthesizable front end.

---
 rtl/dp_pkg.sv | 32 +++
 rtl/dp_beat_counter.sv | 32 +++
 rtl/dp_load_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/dp_pkg.sv
// dp_pkg: shared types and constants for the dotProduct load/compute front end.
`default_nettype none

package dp_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CLEAR   = 3'd2,
    COMPUTE = 3'd3,
    WAIT    = 3'd4
  } state_t;

  localparam int unsigned DP_ADDR_WIDTH     = 4;
  localparam int unsigned DP_RAM_DEPTH      = 1 << DP_ADDR_WIDTH;
  localparam int unsigned DP_PARA_DEG       = 1;
  localparam int unsigned DP_DATA_WIDTH_IN  = 8;
  localparam int unsigned DP_DATA_WIDTH_OUT = 16;

  function automatic int unsigned calc_beats(input int unsigned depth, input int unsigned para);
    return depth / para;
  endfunction

  // LSB of SRAM k inside a packed bus of per-SRAM slices
  function automatic int unsigned slice_lsb(input int unsigned k, input int unsigned para,
                                            input int unsigned width);
    return k * para * width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dp_beat_counter.sv
// dp_beat_counter: loadable up/down counter with a terminal-count compare flag.
`default_nettype none

module dp_beat_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         up,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= up ? count + 1'b1 : count - 1'b1;
    end
  end

  assign tc = (count == term);

endmodule

`default_nettype wire

// File: rtl/dp_load_sequencer.sv
// dp_load_sequencer: streams operand/old-output beats into the dotProduct SRAMs,
// then sequences PE clear, the Computing window and result capture.
`default_nettype none

module dp_load_sequencer
  import dp_pkg::*;
#(
  parameter int Addr_Width     = 4,
  parameter int Ram_Depth      = 1 << Addr_Width,
  parameter int Nums_SRAM_In   = 2,
  parameter int Nums_SRAM_Out  = 1,
  parameter int Para_Deg       = 1,
  parameter int Data_Width_In  = 8,
  parameter int Data_Width_Out = 16,
  parameter int Comp_Latency   = 2
) (
  input  logic                                          clk,
  input  logic                                          reset_n,
  input  logic                                          start,
  input  logic                                          use_old_output,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [Nums_SRAM_In*Para_Deg*Data_Width_In-1:0]   in_data,
  input  logic [Nums_SRAM_Out*Para_Deg*Data_Width_Out-1:0] old_data,
  output logic                                          load_from_file,
  output logic [Nums_SRAM_In*Para_Deg*Data_Width_In-1:0]   input_data_from_file,
  output logic [Nums_SRAM_Out*Para_Deg*Data_Width_Out-1:0] output_data_from_file,
  output logic [Addr_Width-1:0]                         wr_addr,
  output logic                                          Comp_reset,
  output logic                                          PE_reset,
  output logic                                          load_old_output,
  output logic                                          Computing,
  input  logic [Para_Deg*Data_Width_Out*2-1:0]          result,
  output logic [Para_Deg*Data_Width_Out*2-1:0]          result_out,
  output logic                                          done,
  output logic                                          busy
);

  localparam int              CW      = Addr_Width + 1;
  localparam int              BEATS   = int'(calc_beats(Ram_Depth, Para_Deg));
  localparam logic [CW-1:0]   BEATS_C = CW'(BEATS);
  localparam logic [CW-1:0]   LAST_C  = CW'(BEATS - 1);
  localparam logic [CW-1:0]   LAT_C   = CW'(Comp_Latency);
  localparam logic [CW-1:0]   ONE_C   = CW'(1);
  localparam logic [CW-1:0]   TWO_C   = CW'(2);

  if (Ram_Depth % Para_Deg != 0) begin : g_depth_check
    $error("dp_load_sequencer: Ram_Depth must be a multiple of Para_Deg");
  end
  if (Comp_Latency < 1 || Comp_Latency >= (1 << CW)) begin : g_lat_check
    $error("dp_load_sequencer: Comp_Latency out of range");
  end

  state_t          state;
  logic            old_flag;
  logic            hs;
  logic [CW-1:0]   load_count;
  logic            load_tc;
  logic [CW-1:0]   comp_count;
  logic            comp_tc;
  logic            comp_load;
  logic [CW-1:0]   comp_load_val;
  logic [Addr_Width-1:0] next_addr;

  assign hs            = in_valid && in_ready && (state == LOAD);
  assign next_addr     = Addr_Width'(int'(load_count) * Para_Deg);
  // The compute counter is reused for the WAIT phase once COMPUTE ends
  assign comp_load     = (state == CLEAR) || ((state == COMPUTE) && comp_tc);
  assign comp_load_val = (state == CLEAR) ? BEATS_C : LAT_C;

  dp_beat_counter #(.W(CW)) u_load_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     ((state == IDLE) && start),
    .load_val ('0),
    .en       (hs),
    .up       (1'b1),
    .term     (LAST_C),
    .count    (load_count),
    .tc       (load_tc)
  );

  dp_beat_counter #(.W(CW)) u_comp_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (comp_load),
    .load_val (comp_load_val),
    .en       ((state == COMPUTE) || (state == WAIT)),
    .up       (1'b0),
    .term     (ONE_C),
    .count    (comp_count),
    .tc       (comp_tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                 <= IDLE;
      old_flag              <= 1'b0;
      in_ready              <= 1'b0;
      load_from_file        <= 1'b0;
      input_data_from_file  <= '0;
      output_data_from_file <= '0;
      wr_addr               <= '0;
      Comp_reset            <= 1'b0;
      PE_reset              <= 1'b0;
      load_old_output       <= 1'b0;
      Computing             <= 1'b0;
      result_out            <= '0;
      done                  <= 1'b0;
      busy                  <= 1'b0;
    end else begin
      load_from_file <= 1'b0;
      Comp_reset     <= 1'b0;
      PE_reset       <= 1'b0;
      done           <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            old_flag <= use_old_output;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (hs) begin
            load_from_file        <= 1'b1;
            input_data_from_file  <= in_data;
            output_data_from_file <= old_data;
            wr_addr               <= next_addr;
            if (load_tc) begin
              in_ready   <= 1'b0;
              Comp_reset <= 1'b1;
              PE_reset   <= 1'b1;
              state      <= CLEAR;
            end
          end
        end
        CLEAR: begin
          Computing       <= 1'b1;
          load_old_output <= old_flag;
          state           <= COMPUTE;
        end
        COMPUTE: begin
          if (comp_tc) begin
            Computing       <= 1'b0;
            load_old_output <= 1'b0;
            state           <= WAIT;
            if (Comp_Latency == 1) begin
              result_out <= result;
              done       <= 1'b1;
            end
          end
        end
        WAIT: begin
          // done is shown during the final WAIT cycle, so capture one cycle early
          if (comp_tc) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (comp_count == TWO_C) begin
            result_out <= result;
            done       <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
